axi_rd_arbiter_n: RTL and testbench
===================================

Name: axi_rd_arbiter_n

Overview:
- N-master to 1-slave arbiter for the AXI4 read path (AR + R channels) between the core's fetch/load units and the single io_master read port.
- Generalises the existing two-requester address mux:
  - any number of masters;
  - selectable fixed-priority or round-robin arbitration;
  - full AR handshake forwarding;
  - R-channel return routing, with the grant locked until the burst's rlast beat.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8); index 0 = IFU, index 1 = LSU in the default build.
- ADDR_WIDTH, 32, araddr width.
- DATA_WIDTH, 32, rdata width.
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- m_arvalid  in  NUM_MASTERS  per-master AR valid
- m_araddr  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_arlen  in  NUM_MASTERS*8  per-master burst length-1
- m_arready  out  NUM_MASTERS  per-master AR ready
- m_rvalid  out  NUM_MASTERS  per-master R valid
- m_rdata  out  DATA_WIDTH  shared read data (qualified by m_rvalid)
- m_rresp  out  2  shared response
- m_rlast  out  1  shared last flag
- m_rready  in  NUM_MASTERS  per-master R ready
- io_master_arvalid  out  1  slave AR valid
- io_master_arready  in  1  slave AR ready
- io_master_araddr  out  ADDR_WIDTH  slave address
- io_master_arlen  out  8  slave burst length
- io_master_rvalid  in  1  slave R valid
- io_master_rready  out  1  slave R ready
- io_master_rdata  in  DATA_WIDTH  slave read data
- io_master_rresp  in  2  slave response
- io_master_rlast  in  1  slave last flag
- grant  out  NUM_MASTERS  one-hot current owner, 0 in IDLE
- busy  out  1  state != IDLE

Behaviour:
- State machine: IDLE, ADDR, DATA; encoding is free.
- Reset: state=IDLE, grant=0, rr_ptr=NUM_MASTERS-1, all outputs 0.
- IDLE:
  - if any m_arvalid is set, the winner is chosen combinationally and registered into grant at the next edge; state -> ADDR.
  - Fixed mode: highest set index wins.
  - RR mode: search starts at rr_ptr+1 mod NUM_MASTERS and takes the first set index.
- ADDR:
  - io_master_arvalid = m_arvalid[g]; araddr/arlen are muxed from g; m_arready[g] = io_master_arready; all other m_arready = 0.
  - On arvalid&arready: state -> DATA; rr_ptr <= g.
  - If m_arvalid[g] drops before the handshake (protocol violation, tolerated): state -> IDLE, grant -> 0, rr_ptr unchanged.
- DATA:
  - m_rvalid[g] = io_master_rvalid; io_master_rready = m_rready[g]; rdata/rresp/rlast pass through combinationally; other m_rvalid = 0.
  - On rvalid&rready&rlast: state -> IDLE, grant -> 0.
  - Non-last beats keep the grant.
- Outside ADDR: io_master_arvalid=0 and all m_arready=0. Outside DATA: io_master_rready=0 and all m_rvalid=0.
- Latency:
  - Request seen at edge k gives io_master_arvalid high in cycle k+1.
  - At least 1 IDLE cycle separates consecutive transactions.
  - Zero added latency on R beats.
- Other masters' arvalid are ignored (held off) while busy; no preemption.
- A request arriving in the same cycle as the rlast handshake is arbitrated in the following IDLE cycle.
- Reset mid-ADDR/DATA: immediately IDLE with outputs 0. Outstanding slave beats are not drained (system-level reset covers the slave).
- NUM_MASTERS=1: always grants index 0; both modes are identical.

Test Plan:
1. Reset, then m_arvalid=2'b01, araddr0=0x8000_0000, arlen=0; slave arready after 2 cycles, rvalid rdata=0xDEADBEEF rlast=1 -> grant=01; io_master_araddr=0x8000_0000; m_rvalid[0] with 0xDEADBEEF; grant=00 the cycle after.
2. Fixed mode, both masters assert in the same cycle (addr0=0x100, addr1=0x200) -> LSU (index 1) served first with 0x200; IFU served next with 0x100 after one IDLE cycle.
3. RR mode, NUM_MASTERS=4, all four request continuously with single-beat reads -> grant order 0001,0010,0100,1000,0001.
4. Burst arlen=3, second master requesting throughout -> grant stays on the owner through 4 beats including rready stalls; switches only after the rlast handshake.
5. rst asserted during DATA beat 2 of 4 -> next cycle busy=0, grant=0, io_master_rready=0, all m_rvalid=0.
6. Granted master drops arvalid in ADDR before arready -> return to IDLE; rr_ptr unchanged; the other pending master is granted 2 cycles later.

Source files
------------

// File: rtl/axi_rd_arbiter_n.sv
// N-master to 1-slave arbiter for the AXI4 read path (AR + R channels).
// Fixed-priority or round-robin selection; the grant is held from AR request through the rlast beat.
module axi_rd_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RR_MODE     = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]          m_arlen,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [1:0]                        m_rresp,
  output logic                              m_rlast,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic                              io_master_arvalid,
  input  logic                              io_master_arready,
  output logic [ADDR_WIDTH-1:0]             io_master_araddr,
  output logic [7:0]                        io_master_arlen,
  input  logic                              io_master_rvalid,
  output logic                              io_master_rready,
  input  logic [DATA_WIDTH-1:0]             io_master_rdata,
  input  logic [1:0]                        io_master_rresp,
  input  logic                              io_master_rlast,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             win_found;
  logic             any_req;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_MASTERS];
  logic [7:0]            len_arr  [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i] = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[i]  = m_arlen[i*8 +: 8];
  end

  assign any_req = |m_arvalid;

  // Round-robin scans upward from the slot after the last AR winner; fixed mode keeps the highest index.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    if (RR_MODE != 0) begin
      for (int off = 1; off <= NUM_MASTERS; off++) begin
        cand = IDX_W'((int'(rr_ptr) + off) % NUM_MASTERS);
        if (!win_found && m_arvalid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (m_arvalid[i]) win_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= ADDR;
            owner <= win_idx;
            grant <= NUM_MASTERS'(1) << win_idx;
          end
        end
        ADDR: begin
          // A request withdrawn before its handshake releases the bus without moving the RR pointer.
          if (!m_arvalid[owner]) begin
            state <= IDLE;
            grant <= '0;
          end else if (io_master_arready) begin
            state  <= DATA;
            rr_ptr <= owner;
          end
        end
        DATA: begin
          if (io_master_rvalid && m_rready[owner] && io_master_rlast) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Channel routing is purely combinational from the registered owner, so R beats see no added latency.
  always_comb begin
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arlen   = '0;
    m_arready         = '0;
    io_master_rready  = 1'b0;
    m_rvalid          = '0;
    m_rdata           = '0;
    m_rresp           = '0;
    m_rlast           = 1'b0;
    case (state)
      ADDR: begin
        io_master_arvalid = m_arvalid[owner];
        io_master_araddr  = addr_arr[owner];
        io_master_arlen   = len_arr[owner];
        m_arready         = io_master_arready ? grant : '0;
      end
      DATA: begin
        io_master_rready = m_rready[owner];
        m_rvalid         = io_master_rvalid ? grant : '0;
        m_rdata          = io_master_rdata;
        m_rresp          = io_master_rresp;
        m_rlast          = io_master_rlast;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// Scoreboard bench for axi_rd_arbiter_n: a fixed-priority 2-master instance and a round-robin 4-master
// instance share stimulus; a reference model predicts service order and data, a monitor compares.
module tb_axi_rd_arbiter_n;

  localparam int NMAX = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NMAX-1:0]      arv;
  logic [NMAX*AW-1:0]   araddr;
  logic [NMAX*8-1:0]    arlen;
  logic [NMAX-1:0]      rrdy;
  logic                 s_arready, s_rvalid, s_rlast;
  logic [DW-1:0]        s_rdata;
  logic [1:0]           s_rresp;

  logic [1:0]    fx_arready, fx_rvalid, fx_grant, fx_rresp;
  logic [DW-1:0] fx_rdata;
  logic          fx_rlast, fx_arvalid, fx_rready, fx_busy;
  logic [AW-1:0] fx_araddr;
  logic [7:0]    fx_arlen;

  logic [3:0]    rr_arready, rr_rvalid, rr_grant;
  logic [1:0]    rr_rresp;
  logic [DW-1:0] rr_rdata;
  logic          rr_rlast, rr_arvalid, rr_rready, rr_busy;
  logic [AW-1:0] rr_araddr;
  logic [7:0]    rr_arlen;

  axi_rd_arbiter_n #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst),
    .m_arvalid(arv[1:0]), .m_araddr(araddr[2*AW-1:0]), .m_arlen(arlen[15:0]),
    .m_arready(fx_arready), .m_rvalid(fx_rvalid), .m_rdata(fx_rdata), .m_rresp(fx_rresp),
    .m_rlast(fx_rlast), .m_rready(rrdy[1:0]),
    .io_master_arvalid(fx_arvalid), .io_master_arready(s_arready), .io_master_araddr(fx_araddr),
    .io_master_arlen(fx_arlen), .io_master_rvalid(s_rvalid), .io_master_rready(fx_rready),
    .io_master_rdata(s_rdata), .io_master_rresp(s_rresp), .io_master_rlast(s_rlast),
    .grant(fx_grant), .busy(fx_busy)
  );

  axi_rd_arbiter_n #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst),
    .m_arvalid(arv), .m_araddr(araddr), .m_arlen(arlen),
    .m_arready(rr_arready), .m_rvalid(rr_rvalid), .m_rdata(rr_rdata), .m_rresp(rr_rresp),
    .m_rlast(rr_rlast), .m_rready(rrdy),
    .io_master_arvalid(rr_arvalid), .io_master_arready(s_arready), .io_master_araddr(rr_araddr),
    .io_master_arlen(rr_arlen), .io_master_rvalid(s_rvalid), .io_master_rready(rr_rready),
    .io_master_rdata(s_rdata), .io_master_rresp(s_rresp), .io_master_rlast(s_rlast),
    .grant(rr_grant), .busy(rr_busy)
  );

  bit            mode_rr;
  int            cur_n;
  logic [3:0]    o_arready, o_rvalid, o_grant;
  logic [1:0]    o_rresp;
  logic [DW-1:0] o_rdata;
  logic          o_rlast, o_arvalid, o_rready, o_busy;
  logic [AW-1:0] o_araddr;
  logic [7:0]    o_arlen;

  always_comb begin
    if (mode_rr) begin
      o_arready = rr_arready; o_rvalid = rr_rvalid; o_grant = rr_grant;
      o_rresp = rr_rresp; o_rdata = rr_rdata; o_rlast = rr_rlast;
      o_arvalid = rr_arvalid; o_rready = rr_rready; o_busy = rr_busy;
      o_araddr = rr_araddr; o_arlen = rr_arlen;
    end else begin
      o_arready = {2'b00, fx_arready}; o_rvalid = {2'b00, fx_rvalid}; o_grant = {2'b00, fx_grant};
      o_rresp = fx_rresp; o_rdata = fx_rdata; o_rlast = fx_rlast;
      o_arvalid = fx_arvalid; o_rready = fx_rready; o_busy = fx_busy;
      o_araddr = fx_araddr; o_arlen = fx_arlen;
    end
  end

  typedef struct { int m; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int m; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  int  m_ptr;
  logic [AW-1:0] ra [4];
  logic [7:0]    rl [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave data/response are a pure function of the requested address and beat number.
  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a, input int b);
    return a ^ 32'h5EAD_BEEF ^ (32'(b) << 8);
  endfunction

  function automatic logic [1:0] fresp(input logic [AW-1:0] a, input int b);
    return a[3:2] ^ 2'(b);
  endfunction

  // Reference model: masters in 'set' all wait together; predict service order and every response.
  function automatic void plan(input logic [3:0] set, output logic [3:0] first_oh);
    int ord[$];
    if (mode_rr) begin
      for (int k = 1; k <= cur_n; k++) begin
        int idx;
        idx = (m_ptr + k) % cur_n;
        if (set[idx]) ord.push_back(idx);
      end
      m_ptr = ord[ord.size()-1];
    end else begin
      for (int i = cur_n - 1; i >= 0; i--) if (set[i]) ord.push_back(i);
    end
    foreach (ord[j]) begin
      int m;
      m = ord[j];
      ar_q.push_back('{m: m, addr: ra[m], len: rl[m]});
      for (int b = 0; b <= int'(rl[m]); b++)
        r_q.push_back('{m: m, data: fdat(ra[m], b), resp: fresp(ra[m], b), last: (b == int'(rl[m]))});
    end
    first_oh = 4'(1) << ord[0];
  endfunction

  task automatic load_req();
    for (int i = 0; i < NMAX; i++) begin
      araddr[i*AW +: AW] = ra[i];
      arlen[i*8 +: 8]    = rl[i];
    end
  endtask

  task automatic do_reset(input bit new_rr);
    rst = 1'b1; arv = '0; rrdy = '0; araddr = '0; arlen = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = '0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    mode_rr = new_rr;
    cur_n   = new_rr ? 4 : 2;
    @(posedge clk); #1;
    rst   = 1'b0;
    m_ptr = cur_n - 1;
    @(negedge clk);
    check("rst_grant", o_grant, 0);
    check("rst_busy", o_busy, 0);
    check("rst_arvalid", o_arvalid, 0);
    check("rst_rready", o_rready, 0);
    check("rst_arready", o_arready, 0);
    check("rst_rvalid", o_rvalid, 0);
    mon_en = 1'b1;
  endtask

  // Acts as the requesting masters and the slave until every master in 'set' has finished its burst.
  task automatic serve(input logic [3:0] set, input bit lat_chk, input logic [3:0] first_oh);
    logic [3:0]    pend;
    logic [AW-1:0] sb_addr[$];
    logic [7:0]    sb_len[$];
    int            done, want, beat, cyc;
    pend = set; want = $countones(set); done = 0; beat = 0;
    for (cyc = 0; cyc < 3000 && done < want; cyc++) begin
      logic [3:0] drop;
      bit         ar_hs, r_hs;
      @(negedge clk);
      if (lat_chk && cyc == 1) begin
        check("lat_arvalid", o_arvalid, 1);
        check("lat_grant", o_grant, first_oh);
      end
      drop  = pend & o_arready;
      ar_hs = o_arvalid & s_arready;
      r_hs  = s_rvalid & o_rready;
      if (ar_hs) begin
        sb_addr.push_back(o_araddr);
        sb_len.push_back(o_arlen);
      end
      @(posedge clk); #1;
      pend &= ~drop;
      arv = pend;
      if (r_hs) begin
        s_rvalid = 1'b0;
        if (beat == int'(sb_len[0])) begin
          void'(sb_addr.pop_front());
          void'(sb_len.pop_front());
          beat = 0;
          done++;
        end else begin
          beat++;
        end
      end
      if (!s_rvalid && sb_addr.size() > 0 && $urandom_range(0, 3) != 0) begin
        s_rvalid = 1'b1;
        s_rdata  = fdat(sb_addr[0], beat);
        s_rresp  = fresp(sb_addr[0], beat);
        s_rlast  = (beat == int'(sb_len[0]));
      end
      s_arready = 1'($urandom_range(0, 1));
      rrdy      = 4'($urandom) | 4'($urandom);
    end
    check("serve_bursts_done", done, want);
  endtask

  task automatic round(input logic [3:0] set);
    logic [3:0] f1;
    plan(set, f1);
    load_req();
    arv = set;
    serve(set, 1'b1, f1);
  endtask

  task automatic rand_round();
    logic [3:0] set;
    set = 4'($urandom_range(1, (1 << cur_n) - 1));
    for (int i = 0; i < NMAX; i++) begin
      ra[i] = $urandom;
      rl[i] = 8'($urandom_range(0, 3));
    end
    round(set);
  endtask

  initial begin : monitor
    ar_t ea;
    r_t  er;
    bit  idle_chk;
    idle_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        check("post_rlast_grant", o_grant, 0);
        check("post_rlast_busy", o_busy, 0);
        idle_chk = 1'b0;
      end
      if (mon_en && o_arvalid && s_arready) begin
        check("ar_expected", ar_q.size() > 0, 1);
        if (ar_q.size() > 0) begin
          ea = ar_q.pop_front();
          check("ar_grant", o_grant, 4'(1) << ea.m);
          check("ar_ready", o_arready, 4'(1) << ea.m);
          check("ar_addr", o_araddr, ea.addr);
          check("ar_len", o_arlen, ea.len);
        end
      end
      if (mon_en && s_rvalid && o_rready) begin
        check("r_expected", r_q.size() > 0, 1);
        if (r_q.size() > 0) begin
          er = r_q.pop_front();
          check("r_route", o_rvalid & rrdy, 4'(1) << er.m);
          check("r_data", o_rdata, er.data);
          check("r_resp", o_rresp, er.resp);
          check("r_last", o_rlast, er.last);
          if (er.last) idle_chk = 1'b1;
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < NMAX; i++) begin ra[i] = '0; rl[i] = '0; end

    // Fixed priority, two masters.
    do_reset(1'b0);
    ra[0] = 32'h8000_0000;
    round(4'b0001);
    ra[0] = 32'h100; ra[1] = 32'h200;
    round(4'b0011);
    repeat (15) rand_round();

    // Round-robin, four masters.
    do_reset(1'b1);
    for (int i = 0; i < NMAX; i++) begin ra[i] = 32'h1000 * (i + 1); rl[i] = 8'd0; end
    round(4'b1111);
    round(4'b1111);

    // Granted master withdraws in ADDR, then re-requests; the unchanged pointer must pick it again.
    begin
      logic [3:0] f1;
      ra[0] = 32'hA000; ra[1] = 32'hB000; rl[0] = 8'd1; rl[1] = 8'd0;
      plan(4'b0011, f1);
      load_req();
      s_arready = 1'b0;
      arv = 4'b0011;
      @(posedge clk); #1;
      arv = 4'b0010;
      @(negedge clk);
      check("drop_grant", o_grant, 4'b0001);
      check("drop_arvalid", o_arvalid, 0);
      @(posedge clk); #1;
      arv = 4'b0011;
      @(negedge clk);
      check("drop_idle_grant", o_grant, 0);
      check("drop_idle_busy", o_busy, 0);
      serve(4'b0011, 1'b1, f1);
    end

    ra[0] = 32'hC000; ra[2] = 32'hE000; rl[0] = 8'd3; rl[2] = 8'd3;
    round(4'b0101);
    repeat (15) rand_round();

    // Reset while the third of four beats is on the bus.
    mon_en = 1'b0;
    ra[0] = 32'h4000; rl[0] = 8'd3;
    load_req();
    arv = 4'b0001; s_arready = 1'b1; rrdy = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arv = '0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = fdat(ra[0], 0); s_rresp = fresp(ra[0], 0);
    @(posedge clk); #1;
    s_rdata = fdat(ra[0], 1); s_rresp = fresp(ra[0], 1);
    @(posedge clk); #1;
    s_rdata = fdat(ra[0], 2); s_rresp = fresp(ra[0], 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_rvalid_before", o_rvalid, 4'b0001);
    check("rst_mid_data_before", o_rdata, fdat(ra[0], 2));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_grant", o_grant, 0);
    check("rst_mid_rready", o_rready, 0);
    check("rst_mid_rvalid", o_rvalid, 0);
    s_rvalid = 1'b0;

    check("ar_queue_drained", ar_q.size(), 0);
    check("r_queue_drained", r_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
